// File: rtl/board_rst_seq_pkg.sv
// board_rst_seq_pkg
//   Shared types and width helpers for the board reset sequencer.
//   rst_seq_state_e : FSM state encoding, also driven out on the state port.
//   cnt_width       : width of the shared down-counter for the largest load.
//   safe_clog2      : $clog2 clamped to at least 1 bit.
package board_rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    WAIT_LINK = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } rst_seq_state_e;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_rst_cnt.sv
// board_rst_cnt
//   Loadable saturating down-counter shared by the sequencer phases.
//   clk      : clock
//   rst_n    : synchronous active-low reset (count -> 0)
//   load     : load load_val (takes priority over en)
//   load_val : value to load
//   en       : decrement by one, sticking at zero
//   zero     : count is zero
module board_rst_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/board_rst_seq.sv
// board_rst_seq
//   Multi-channel reset sequencer: holds all channel resets, releases them in
//   staggered order, waits for all links up, and (with the watchdog compiled
//   in) re-sequences on link-up timeout or link drop up to MAX_RETRY times.
//   Optional feature macro: RST_SEQ_WATCHDOG_EN (timeout, retry, fail).
// Ports:
//   sys_clk   : sole clock
//   sys_rst_n : synchronous active-low reset
//   start     : level; 1 runs the sequence, 0 forces IDLE
//   link_up   : per-channel link status (sys_clk domain)
//   ch_rst_n  : per-channel active-low reset
//   done      : all links up (RUN)
//   fail      : retries exhausted (FAIL); tied 0 without watchdog
//   link_drop : one-cycle pulse on link loss in RUN
//   retry_cnt : re-sequences consumed; tied 0 without watchdog
//   state     : current FSM state encoding
module board_rst_seq
  import board_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned HOLD_CYCLES    = 500,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned LINKUP_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst_n,
  input  logic                                   start,
  input  logic [NUM_CH-1:0]                      link_up,
  output logic [NUM_CH-1:0]                      ch_rst_n,
  output logic                                   done,
  output logic                                   fail,
  output logic                                   link_drop,
  output logic [safe_clog2(MAX_RETRY+1)-1:0]     retry_cnt,
  output logic [2:0]                             state
);

  localparam int unsigned CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, LINKUP_TIMEOUT);
  localparam int unsigned RW = safe_clog2(MAX_RETRY + 1);
  localparam int unsigned IW = safe_clog2(NUM_CH);

  // Phase loads are one less than the phase length: the transition is taken
  // in the cycle the counter reads zero.
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LD  = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

`ifdef RST_SEQ_WATCHDOG_EN
  // WAIT_LINK spans LINKUP_TIMEOUT+1 cycles including the timeout cycle.
  localparam logic [CW-1:0] WAIT_LD   = CW'(LINKUP_TIMEOUT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic          fail_q;
  logic [RW-1:0] retry_q;
  logic          retry_ok;
  assign retry_ok  = (retry_q < RETRY_MAX);
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
`else
  localparam logic [CW-1:0] WAIT_LD = '0;
  assign fail      = 1'b0;
  assign retry_cnt = '0;
`endif

  rst_seq_state_e st;
  logic [IW-1:0]  idx;
  logic           all_up;
  logic           cnt_load;
  logic [CW-1:0]  cnt_load_val;
  logic           cnt_en;
  logic           cnt_zero;

  assign all_up = &link_up;
  assign state  = st;

  board_rst_cnt #(.WIDTH(CW)) u_cnt (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // Counter control mirrors the FSM transitions below so the next phase
  // starts with its length already loaded.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    if (!start) begin
      cnt_load = 1'b1;
    end else begin
      case (st)
        IDLE: begin
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end
        HOLD: begin
          if (cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = (LAST_IDX == '0) ? WAIT_LD : STAG_LD;
          end else begin
            cnt_en = 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = (idx == LAST_IDX) ? WAIT_LD : STAG_LD;
          end else begin
            cnt_en = 1'b1;
          end
        end
`ifdef RST_SEQ_WATCHDOG_EN
        WAIT_LINK: begin
          if (!all_up && cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = retry_ok ? HOLD_LD : '0;
          end else begin
            cnt_en = 1'b1;
          end
        end
        RUN: begin
          if (!all_up) begin
            cnt_load     = 1'b1;
            cnt_load_val = retry_ok ? HOLD_LD : '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || !start) begin
      st        <= IDLE;
      ch_rst_n  <= '0;
      done      <= 1'b0;
      link_drop <= 1'b0;
      idx       <= '0;
`ifdef RST_SEQ_WATCHDOG_EN
      fail_q    <= 1'b0;
      retry_q   <= '0;
`endif
    end else begin
      link_drop <= 1'b0;
      case (st)
        IDLE: begin
          ch_rst_n <= '0;
          idx      <= '0;
          st       <= HOLD;
        end
        HOLD: begin
          // Channel 0 is released on the HOLD exit edge itself.
          if (cnt_zero) begin
            ch_rst_n[0] <= 1'b1;
            if (LAST_IDX == '0) begin
              st <= WAIT_LINK;
            end else begin
              idx <= IW'(1);
              st  <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (cnt_zero) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (idx == IW'(k)) ch_rst_n[k] <= 1'b1;
            end
            if (idx == LAST_IDX) st <= WAIT_LINK;
            else                 idx <= idx + 1'b1;
          end
        end
        WAIT_LINK: begin
          if (all_up) begin
            done <= 1'b1;
            st   <= RUN;
          end
`ifdef RST_SEQ_WATCHDOG_EN
          else if (cnt_zero) begin
            ch_rst_n <= '0;
            idx      <= '0;
            if (retry_ok) begin
              retry_q <= retry_q + 1'b1;
              st      <= HOLD;
            end else begin
              fail_q <= 1'b1;
              st     <= FAIL;
            end
          end
`endif
        end
        RUN: begin
          if (!all_up) begin
            link_drop <= 1'b1;
            done      <= 1'b0;
`ifdef RST_SEQ_WATCHDOG_EN
            ch_rst_n  <= '0;
            idx       <= '0;
            if (retry_ok) begin
              retry_q <= retry_q + 1'b1;
              st      <= HOLD;
            end else begin
              fail_q <= 1'b1;
              st     <= FAIL;
            end
`else
            st <= WAIT_LINK;
`endif
          end
        end
        FAIL: begin
          ch_rst_n <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
